aq_mmu_ptw_walker: RTL and testbench



---
 rtl/aq_mmu_ptw_walker_pkg.sv | 41 ++++
 rtl/aq_mmu_ptw_walker_if.sv | 40 ++++
 rtl/aq_mmu_ptw_walker_pte_chk.sv | 40 ++++
 rtl/aq_mmu_ptw_walker.sv | 137 +++++++++++++
 tb/tb_aq_mmu_ptw_walker.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aq_mmu_ptw_walker_pkg.sv
// Shared MMU definitions for the Sv39 page-table walker: address widths,
// PTE field positions, page-size and FSM encodings, and the VPN slice helper.
package aq_mmu_ptw_walker_pkg;
  localparam int PA_WIDTH  = 40;
  localparam int PPN_WIDTH = PA_WIDTH - 12;

  // PTE flag bit positions
  localparam int PTE_V = 0;
  localparam int PTE_R = 1;
  localparam int PTE_W = 2;
  localparam int PTE_X = 3;
  localparam int PTE_U = 4;
  localparam int PTE_G = 5;
  localparam int PTE_A = 6;
  localparam int PTE_D = 7;
  localparam int PTE_PPN_LSB = 10;
  localparam int PTE_PPN_MSB = 37;
  localparam int PTE_RSV_LSB = 38;
  localparam int PTE_RSV_MSB = 53;

  typedef enum logic [1:0] {
    PGS_4K = 2'd0,
    PGS_2M = 2'd1,
    PGS_1G = 2'd2
  } pgs_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WALK = 2'b01,
    ST_RESP = 2'b10
  } ptw_state_e;

  // VPN[level] out of the 27-bit Sv39 VPN
  function automatic logic [8:0] vpn_slice(input logic [26:0] vpn, input logic [1:0] lvl);
    case (lvl)
      2'd2:    return vpn[26:18];
      2'd1:    return vpn[17:9];
      default: return vpn[8:0];
    endcase
  endfunction
endpackage

// File: rtl/aq_mmu_ptw_walker_if.sv
// TLB <-> walker <-> LSU signal bundle.
//   master: the walker (drives PTE read request and TLB result)
//   slave : the environment (TLB, CP0 satp, LSU data return)
interface aq_mmu_ptw_walker_if;
  import aq_mmu_ptw_walker_pkg::*;

  logic                 tlb_ptw_req;
  logic [26:0]          tlb_ptw_vpn;
  logic                 tlb_ptw_abort;
  logic [PPN_WIDTH-1:0] cp0_mmu_satp_ppn;
  logic                 mmu_lsu_data_req;
  logic [PA_WIDTH-1:0]  mmu_lsu_data_req_addr;
  logic                 mmu_lsu_data_req_size;
  logic                 lsu_mmu_data_vld;
  logic [63:0]          lsu_mmu_data;
  logic                 lsu_mmu_bus_error;
  logic                 ptw_tlb_busy;
  logic                 ptw_tlb_done;
  logic [PPN_WIDTH-1:0] ptw_tlb_ppn;
  logic [7:0]           ptw_tlb_flg;
  logic [1:0]           ptw_tlb_pgs;
  logic                 ptw_tlb_pf;
  logic                 ptw_tlb_acc_err;

  modport master (
    input  tlb_ptw_req, tlb_ptw_vpn, tlb_ptw_abort, cp0_mmu_satp_ppn,
           lsu_mmu_data_vld, lsu_mmu_data, lsu_mmu_bus_error,
    output mmu_lsu_data_req, mmu_lsu_data_req_addr, mmu_lsu_data_req_size,
           ptw_tlb_busy, ptw_tlb_done, ptw_tlb_ppn, ptw_tlb_flg, ptw_tlb_pgs,
           ptw_tlb_pf, ptw_tlb_acc_err
  );

  modport slave (
    output tlb_ptw_req, tlb_ptw_vpn, tlb_ptw_abort, cp0_mmu_satp_ppn,
           lsu_mmu_data_vld, lsu_mmu_data, lsu_mmu_bus_error,
    input  mmu_lsu_data_req, mmu_lsu_data_req_addr, mmu_lsu_data_req_size,
           ptw_tlb_busy, ptw_tlb_done, ptw_tlb_ppn, ptw_tlb_flg, ptw_tlb_pgs,
           ptw_tlb_pf, ptw_tlb_acc_err
  );
endinterface

// File: rtl/aq_mmu_ptw_walker_pte_chk.sv
// Combinational Sv39 PTE decode for one walk level.
//   pte      : PTE returned by the LSU
//   level    : current walk level (2..0)
//   leaf     : PTE is a leaf (R|X)
//   pf       : page fault (invalid, W-without-R, misaligned superpage, pointer at level 0)
//   acc_err  : reserved bits 53:38 non-zero (outranks pf)
//   next_ppn : PPN field, next table base or leaf PPN
module aq_mmu_pte_chk
  import aq_mmu_ptw_walker_pkg::*;
(
  input  logic [63:0]          pte,
  input  logic [1:0]           level,
  output logic                 leaf,
  output logic                 pf,
  output logic                 acc_err,
  output logic [PPN_WIDTH-1:0] next_ppn
);
  logic misaligned;
  logic unused_pte_bits;

  assign unused_pte_bits = ^{pte[63:54], pte[9:4]};

  assign acc_err  = |pte[PTE_RSV_MSB:PTE_RSV_LSB];
  assign leaf     = pte[PTE_R] | pte[PTE_X];
  assign next_ppn = pte[PTE_PPN_MSB:PTE_PPN_LSB];

  // Superpages need the PPN bits below their size to be zero
  always_comb begin
    misaligned = 1'b0;
    case (level)
      2'd2:    misaligned = |pte[PTE_PPN_LSB+17:PTE_PPN_LSB];
      2'd1:    misaligned = |pte[PTE_PPN_LSB+8:PTE_PPN_LSB];
      default: misaligned = 1'b0;
    endcase
  end

  assign pf = !acc_err &&
              (!pte[PTE_V] || (!pte[PTE_R] && pte[PTE_W]) ||
               (leaf && misaligned) || (!leaf && level == 2'd0));
endmodule

// File: rtl/aq_mmu_ptw_walker.sv
// Sv39 hardware page-table walker.
//   forever_cpuclk : clock
//   cpurst         : asynchronous active-high reset
//   bus            : master side of the TLB/CP0/LSU bundle
// One 8-byte PTE read per level; the request is held until the LSU answers,
// dropped for exactly one cycle, then raised for the next level. Results
// come back to the TLB as a one-cycle done strobe.
module aq_mmu_ptw_walker #(
  parameter int PA_WIDTH  = aq_mmu_ptw_walker_pkg::PA_WIDTH,
  parameter int PPN_WIDTH = PA_WIDTH - 12
) (
  input logic                  forever_cpuclk,
  input logic                  cpurst,
  aq_mmu_ptw_walker_if.master  bus
);
  import aq_mmu_ptw_walker_pkg::*;

  ptw_state_e           state;
  logic [1:0]           level;
  logic [26:0]          vpn;
  logic [PPN_WIDTH-1:0] base_ppn;
  logic                 abort_pend;
  logic                 req;
  logic [PA_WIDTH-1:0]  addr;
  logic                 done;
  logic [PPN_WIDTH-1:0] res_ppn;
  logic [7:0]           res_flg;
  logic [1:0]           res_pgs;
  logic                 res_pf;
  logic                 res_acc;

  logic                 chk_leaf, chk_pf, chk_acc;
  logic [PPN_WIDTH-1:0] chk_ppn;
  logic                 resp;

  aq_mmu_pte_chk u_pte_chk (
    .pte      (bus.lsu_mmu_data),
    .level    (level),
    .leaf     (chk_leaf),
    .pf       (chk_pf),
    .acc_err  (chk_acc),
    .next_ppn (chk_ppn)
  );

  assign resp = req & (bus.lsu_mmu_data_vld | bus.lsu_mmu_bus_error);

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      state      <= ST_IDLE;
      level      <= 2'd2;
      vpn        <= '0;
      base_ppn   <= '0;
      abort_pend <= 1'b0;
      req        <= 1'b0;
      addr       <= '0;
      done       <= 1'b0;
      res_ppn    <= '0;
      res_flg    <= '0;
      res_pgs    <= '0;
      res_pf     <= 1'b0;
      res_acc    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.tlb_ptw_req) begin
            vpn      <= bus.tlb_ptw_vpn;
            level    <= 2'd2;
            base_ppn <= bus.cp0_mmu_satp_ppn;
            req      <= 1'b1;
            addr     <= {bus.cp0_mmu_satp_ppn, vpn_slice(bus.tlb_ptw_vpn, 2'd2), 3'b000};
            state    <= ST_WALK;
          end
        end
        ST_WALK: begin
          if (req) begin
            if (bus.tlb_ptw_abort) abort_pend <= 1'b1;
            if (resp) begin
              req <= 1'b0;
              // An abort seen at or before the response swallows the result
              if (abort_pend || bus.tlb_ptw_abort) begin
                abort_pend <= 1'b0;
                state      <= ST_IDLE;
              end else if (bus.lsu_mmu_bus_error || chk_acc) begin
                res_acc <= 1'b1;
                done    <= 1'b1;
                state   <= ST_RESP;
              end else if (chk_pf) begin
                res_pf <= 1'b1;
                done   <= 1'b1;
                state  <= ST_RESP;
              end else if (chk_leaf) begin
                res_ppn <= chk_ppn;
                res_flg <= bus.lsu_mmu_data[7:0];
                res_pgs <= level;
                done    <= 1'b1;
                state   <= ST_RESP;
              end else begin
                base_ppn <= chk_ppn;
                level    <= level - 2'd1;
              end
            end
          end else begin
            // One-cycle request gap between levels; nothing is outstanding,
            // so an abort here can finish the walk at once.
            if (bus.tlb_ptw_abort) begin
              state <= ST_IDLE;
            end else begin
              req  <= 1'b1;
              addr <= {base_ppn, vpn_slice(vpn, level), 3'b000};
            end
          end
        end
        ST_RESP: begin
          done    <= 1'b0;
          res_ppn <= '0;
          res_flg <= '0;
          res_pgs <= '0;
          res_pf  <= 1'b0;
          res_acc <= 1'b0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.mmu_lsu_data_req      = req;
  assign bus.mmu_lsu_data_req_addr = addr;
  assign bus.mmu_lsu_data_req_size = 1'b1;
  assign bus.ptw_tlb_busy          = (state != ST_IDLE);
  assign bus.ptw_tlb_done          = done;
  assign bus.ptw_tlb_ppn           = res_ppn;
  assign bus.ptw_tlb_flg           = res_flg;
  assign bus.ptw_tlb_pgs           = res_pgs;
  assign bus.ptw_tlb_pf            = res_pf;
  assign bus.ptw_tlb_acc_err       = res_acc;
endmodule

// File: tb/tb_aq_mmu_ptw_walker.sv
// Bench for aq_mmu_ptw_walker: directed Sv39 walks plus randomized page
// tables, a random-latency LSU responder, and a walk-level reference model.
module tb_aq_mmu_ptw_walker;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  aq_mmu_ptw_walker_if bus();

  aq_mmu_ptw_walker dut (
    .forever_cpuclk (clk),
    .cpurst         (rst),
    .bus            (bus.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // page-table memory and bus-error addresses
  logic [63:0] mem  [logic [39:0]];
  bit          berr [logic [39:0]];
  logic [39:0] obs_q[$];
  logic [39:0] exp_q[$];

  bit          new_walk = 1'b1;
  bit          pending = 1'b0;
  bit          resp_last = 1'b0;
  int          last_resp = 0;
  int          lat = 0;
  logic [39:0] cur_addr = '0;

  logic [27:0] r_ppn;
  logic [7:0]  r_flg;
  logic [1:0]  r_pgs;
  logic        r_pf, r_acc;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [39:0] pte_addr(input logic [27:0] base, input logic [26:0] vpn, input int lvl);
    longint unsigned a;
    a = longint'(base) * 4096 + ((longint'(vpn) >> (9 * lvl)) & 511) * 8;
    return a[39:0];
  endfunction

  // Reference walk straight from the Sv39 rules
  function automatic void model_walk(input logic [27:0] satp, input logic [26:0] vpn,
                                     output logic pf, output logic acc, output logic [27:0] ppn,
                                     output logic [7:0] flg, output logic [1:0] pgs);
    logic [27:0] base;
    logic [39:0] a;
    logic [63:0] pte;
    longint unsigned ppn_l;
    pf = 0; acc = 0; ppn = 0; flg = 0; pgs = 0;
    base = satp;
    exp_q.delete();
    for (int lvl = 2; lvl >= 0; lvl--) begin
      a = pte_addr(base, vpn, lvl);
      exp_q.push_back(a);
      if (berr.exists(a)) begin acc = 1; return; end
      pte = mem.exists(a) ? mem[a] : 64'h0;
      if (pte[53:38] != 16'h0) begin acc = 1; return; end
      if (!pte[0] || (!pte[1] && pte[2])) begin pf = 1; return; end
      ppn_l = longint'(pte[37:10]);
      if (pte[1] || pte[3]) begin
        if (lvl > 0 && (ppn_l % (longint'(1) << (9 * lvl))) != 0) begin pf = 1; return; end
        ppn = pte[37:10]; flg = pte[7:0]; pgs = 2'(lvl);
        return;
      end
      if (lvl == 0) begin pf = 1; return; end
      base = pte[37:10];
    end
  endfunction

  // LSU: answers each request after 0..3 extra cycles, checks address
  // stability, the drop after a response and the one-cycle level gap.
  initial begin
    bus.lsu_mmu_data_vld = 0; bus.lsu_mmu_bus_error = 0; bus.lsu_mmu_data = '0;
    forever begin
      @(negedge clk);
      bus.lsu_mmu_data_vld = 0; bus.lsu_mmu_bus_error = 0; bus.lsu_mmu_data = '0;
      if (rst) begin
        pending = 0; resp_last = 0;
      end else if (resp_last) begin
        chk("req_drop", 64'(bus.mmu_lsu_data_req), 64'd0);
        resp_last = 0;
      end else if (bus.mmu_lsu_data_req) begin
        if (!pending) begin
          pending = 1;
          cur_addr = bus.mmu_lsu_data_req_addr;
          obs_q.push_back(cur_addr);
          lat = $urandom_range(0, 3);
          if (!new_walk) chk("req_gap", 64'(cyc - last_resp), 64'd2);
          new_walk = 0;
        end else begin
          chk("addr_hold", 64'(bus.mmu_lsu_data_req_addr), 64'(cur_addr));
        end
        if (lat == 0) begin
          pending = 0; resp_last = 1; last_resp = cyc;
          if (berr.exists(cur_addr)) begin
            bus.lsu_mmu_bus_error = 1;
            bus.lsu_mmu_data_vld  = ($urandom_range(0, 1) == 1);
            bus.lsu_mmu_data      = mem.exists(cur_addr) ? mem[cur_addr] : 64'h0;
          end else begin
            bus.lsu_mmu_data_vld = 1;
            bus.lsu_mmu_data     = mem.exists(cur_addr) ? mem[cur_addr] : 64'h0;
          end
        end else begin
          lat--;
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge where busy is seen low.
  task automatic run_walk(input logic [27:0] satp, input logic [26:0] vpn,
                          input int abort_at, input bit do_stray);
    logic epf, eacc;
    logic [27:0] eppn;
    logic [7:0] eflg;
    logic [1:0] epgs;
    int k, ndone, done_cyc;
    bit aborted;
    model_walk(satp, vpn, epf, eacc, eppn, eflg, epgs);
    obs_q.delete();
    new_walk = 1; ndone = 0; done_cyc = 0; aborted = 0;
    r_ppn = '0; r_flg = '0; r_pgs = '0; r_pf = 0; r_acc = 0;
    bus.cp0_mmu_satp_ppn = satp; bus.tlb_ptw_vpn = vpn; bus.tlb_ptw_req = 1;
    @(negedge clk);
    bus.tlb_ptw_req = 0;
    chk("start_req", 64'(bus.mmu_lsu_data_req), 64'd1);
    chk("start_addr", 64'(bus.mmu_lsu_data_req_addr), 64'(pte_addr(satp, vpn, 2)));
    k = 0;
    while (bus.ptw_tlb_busy && k < 300) begin
      if (bus.ptw_tlb_done) begin
        ndone++; done_cyc = cyc;
        r_ppn = bus.ptw_tlb_ppn; r_flg = bus.ptw_tlb_flg; r_pgs = bus.ptw_tlb_pgs;
        r_pf = bus.ptw_tlb_pf; r_acc = bus.ptw_tlb_acc_err;
        chk("res_pf", 64'(r_pf), 64'(epf));
        chk("res_acc", 64'(r_acc), 64'(eacc));
        chk("res_ppn", 64'(r_ppn), 64'(eppn));
        chk("res_flg", 64'(r_flg), 64'(eflg));
        chk("res_pgs", 64'(r_pgs), 64'(epgs));
      end
      if (abort_at >= 0 && !aborted && k >= abort_at && bus.mmu_lsu_data_req) begin
        bus.tlb_ptw_abort = 1; aborted = 1;
      end
      if (do_stray && k == 2) begin
        bus.tlb_ptw_req = 1; bus.tlb_ptw_vpn = ~vpn; bus.cp0_mmu_satp_ppn = ~satp;
      end
      @(negedge clk);
      bus.tlb_ptw_abort = 0; bus.tlb_ptw_req = 0;
      bus.tlb_ptw_vpn = vpn; bus.cp0_mmu_satp_ppn = satp;
      k++;
    end
    chk("walk_in_budget", 64'(k < 300), 64'd1);
    chk("done_clear", 64'(bus.ptw_tlb_done), 64'd0);
    if (aborted) begin
      chk("abort_no_done", 64'(ndone), 64'd0);
      chk("abort_busy_drop", 64'(cyc - last_resp), 64'd1);
      chk("abort_req_low", 64'(bus.mmu_lsu_data_req), 64'd0);
      chk("abort_req_bound", 64'(obs_q.size() <= exp_q.size()), 64'd1);
    end else begin
      chk("done_once", 64'(ndone), 64'd1);
      chk("done_lat", 64'(done_cyc - last_resp), 64'd1);
      chk("idle_lat", 64'(cyc - last_resp), 64'd2);
      chk("req_count", 64'(obs_q.size()), 64'(exp_q.size()));
    end
    foreach (obs_q[i]) if (i < exp_q.size()) chk("pte_addr", 64'(obs_q[i]), 64'(exp_q[i]));
  endtask

  task automatic build_path(input logic [27:0] satp, input logic [26:0] vpn);
    logic [27:0] base, ppn;
    logic [39:0] a;
    logic [63:0] pte;
    int kind;
    bit more;
    mem.delete(); berr.delete();
    base = satp; more = 1;
    for (int lvl = 2; lvl >= 0 && more; lvl--) begin
      a = pte_addr(base, vpn, lvl);
      ppn = 28'($urandom);
      kind = $urandom_range(0, 11);
      pte = {10'($urandom), 16'h0, ppn, 2'b00, 4'($urandom), 4'b0000};
      more = 0;
      case (kind)
        0: berr[a] = 1'b1;
        1: begin pte[38 + $urandom_range(0, 15)] = 1'b1; pte[3:0] = 4'b0011; end
        2: pte[3:0] = 4'($urandom) & 4'b1110;
        3: pte[3:0] = 4'b0101 | (4'($urandom) & 4'b1000);
        4, 5: begin
          pte[3:0] = 4'b0011 | (4'($urandom) & 4'b1100);
          if (lvl == 2) pte[27:10] = '0;
          if (lvl == 1) pte[18:10] = '0;
        end
        6: pte[3:0] = 4'b1001 | (4'($urandom) & 4'b0010);
        default: begin pte[3:0] = 4'b0001; base = ppn; more = 1; end
      endcase
      mem[a] = pte;
    end
  endtask

  task automatic set_chain(input logic [26:0] vpn, input logic [63:0] l2, input logic [63:0] l1,
                           input logic [63:0] l0);
    mem.delete(); berr.delete();
    mem[pte_addr(28'h80000, vpn, 2)] = l2;
    mem[pte_addr(28'h80002, vpn, 1)] = l1;
    mem[pte_addr(28'h80003, vpn, 0)] = l0;
  endtask

  initial begin
    logic [26:0] vpn;
    vpn = 27'h040201;
    bus.tlb_ptw_req = 0; bus.tlb_ptw_abort = 0; bus.tlb_ptw_vpn = '0; bus.cp0_mmu_satp_ppn = '0;
    rst = 1;
    repeat (2) @(negedge clk);
    chk("rst_req", 64'(bus.mmu_lsu_data_req), 64'd0);
    chk("rst_addr", 64'(bus.mmu_lsu_data_req_addr), 64'd0);
    chk("rst_size", 64'(bus.mmu_lsu_data_req_size), 64'd1);
    chk("rst_busy", 64'(bus.ptw_tlb_busy), 64'd0);
    chk("rst_done", 64'(bus.ptw_tlb_done), 64'd0);
    chk("rst_res", 64'({bus.ptw_tlb_ppn, bus.ptw_tlb_flg, bus.ptw_tlb_pgs,
                        bus.ptw_tlb_pf, bus.ptw_tlb_acc_err}), 64'd0);
    rst = 0;
    @(negedge clk);

    // three-level walk to a 4K leaf, with a stray request while busy
    set_chain(vpn, 64'h2000_0801, 64'h2000_0C01, 64'h2000_10CF);
    run_walk(28'h80000, vpn, -1, 1);
    chk("chain_ppn", 64'(r_ppn), 64'h80004);
    chk("chain_flg", 64'(r_flg), 64'hCF);
    chk("chain_pgs", 64'(r_pgs), 64'd0);
    chk("chain_pf", 64'(r_pf), 64'd0);

    // aligned 1G leaf
    set_chain(vpn, 64'h2000_00CF, 64'h0, 64'h0);
    run_walk(28'h80000, vpn, -1, 0);
    chk("giga_pgs", 64'(r_pgs), 64'd2);
    chk("giga_ppn", 64'(r_ppn), 64'h80000);

    // misaligned 1G leaf
    set_chain(vpn, 64'h2000_04CF, 64'h0, 64'h0);
    run_walk(28'h80000, vpn, -1, 0);
    chk("giga_mis_pf", 64'(r_pf), 64'd1);
    chk("giga_mis_ppn", 64'(r_ppn), 64'd0);

    // invalid L1, pointer at L0
    set_chain(vpn, 64'h2000_0801, 64'h0, 64'h0);
    run_walk(28'h80000, vpn, -1, 0);
    chk("l1_inv_pf", 64'(r_pf), 64'd1);
    set_chain(vpn, 64'h2000_0801, 64'h2000_0C01, 64'h01);
    run_walk(28'h80000, vpn, -1, 0);
    chk("l0_ptr_pf", 64'(r_pf), 64'd1);

    // bus error at level 1 beats an otherwise good leaf
    set_chain(vpn, 64'h2000_0801, 64'h2000_00CF, 64'h0);
    berr[pte_addr(28'h80002, vpn, 1)] = 1'b1;
    run_walk(28'h80000, vpn, -1, 0);
    chk("berr_acc", 64'(r_acc), 64'd1);
    chk("berr_pf", 64'(r_pf), 64'd0);

    // reserved bit 40
    set_chain(vpn, 64'h0000_0100_2000_00CF, 64'h0, 64'h0);
    run_walk(28'h80000, vpn, -1, 0);
    chk("rsv_acc", 64'(r_acc), 64'd1);

    // abort during the walk
    set_chain(vpn, 64'h2000_0801, 64'h2000_0C01, 64'h2000_10CF);
    run_walk(28'h80000, vpn, 0, 1);

    // randomized page tables
    for (int w = 0; w < 40; w++) begin
      logic [27:0] s;
      logic [26:0] v;
      s = 28'($urandom); v = 27'($urandom);
      build_path(s, v);
      run_walk(s, v, ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 6)) : -1,
               $urandom_range(0, 2) == 0);
    end

    // reset in the middle of a walk
    set_chain(vpn, 64'h2000_0801, 64'h2000_0C01, 64'h2000_10CF);
    new_walk = 1;
    bus.cp0_mmu_satp_ppn = 28'h80000; bus.tlb_ptw_vpn = vpn; bus.tlb_ptw_req = 1;
    @(negedge clk);
    bus.tlb_ptw_req = 0;
    repeat (3) @(negedge clk);
    #2 rst = 1;
    #1;
    chk("midrst_req", 64'(bus.mmu_lsu_data_req), 64'd0);
    chk("midrst_addr", 64'(bus.mmu_lsu_data_req_addr), 64'd0);
    chk("midrst_busy", 64'(bus.ptw_tlb_busy), 64'd0);
    chk("midrst_done", 64'(bus.ptw_tlb_done), 64'd0);
    chk("midrst_size", 64'(bus.mmu_lsu_data_req_size), 64'd1);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    run_walk(28'h80000, vpn, -1, 0);
    chk("post_rst_ppn", 64'(r_ppn), 64'h80004);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
